pipe_stage_skid_reg: RTL and testbench

//  Generalised inter-stage pipeline register (IF/ID..MEM/WB successor) with a valid/ready handshake,
//  a 2-entry skid buffer, flush, and bubble insertion. Carries an opaque control field and data payload.

---
 rtl/pipe_stage_skid_reg.sv | 118 +++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry skid
// buffer. The main entry drives the outputs. The skid entry absorbs one extra
// entry so that in_ready can be registered, with no combinational path from
// out_ready. Flush kills every held entry. Bubbles (out_valid=0) always carry
// a zero control field.
module pipe_stage_skid_reg #(
  parameter int unsigned             CTRL_W   = 2,
  parameter int unsigned             DATA_W   = 69,
  parameter logic [DATA_W-1:0]       RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [1:0]        occ_r;

  logic push;
  logic pop;

  // Handshake qualifiers, both built from registered state only on our side
  always_comb begin
    push = in_valid & in_ready_r;
    pop  = out_valid_r & out_ready;
  end

  // State machine with registered in_ready/out_valid/occupancy; main_ctrl is
  // zeroed on every transition to EMPTY so the bubble control field is 0
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state       <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      occ_r       <= 2'd0;
      main_ctrl   <= '0;
      main_data   <= RST_DATA;
      skid_ctrl   <= '0;
      skid_data   <= RST_DATA;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            main_ctrl   <= in_ctrl;
            main_data   <= in_data;
            state       <= ONE;
            out_valid_r <= 1'b1;
            occ_r       <= 2'd1;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (push) begin
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
            state      <= FULL;
            in_ready_r <= 1'b0;
            occ_r      <= 2'd2;
          end else if (pop) begin
            main_ctrl   <= '0;
            state       <= EMPTY;
            out_valid_r <= 1'b0;
            occ_r       <= 2'd0;
          end
        end
        FULL: begin
          if (pop) begin
            main_ctrl  <= skid_ctrl;
            main_data  <= skid_data;
            state      <= ONE;
            in_ready_r <= 1'b1;
            occ_r      <= 2'd1;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          occ_r       <= 2'd0;
          main_ctrl   <= '0;
        end
      endcase
    end
  end

  // Outputs are straight register reads
  always_comb begin
    in_ready  = in_ready_r;
    out_valid = out_valid_r;
    out_ctrl  = main_ctrl;
    out_data  = main_data;
    occupancy = occ_r;
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: directed vector table followed
// by a randomized valid/ready run against a queue-based scoreboard.
module tb_pipe_stage_skid_reg;

  localparam int unsigned CTRL_W = 2;
  localparam int unsigned DATA_W = 69;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid_reg #(
    .CTRL_W  (CTRL_W),
    .DATA_W  (DATA_W),
    .RST_DATA('0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic              flush;
    logic              iv;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic              ordy;
    logic              e_ir;
    logic              e_ov;
    logic [CTRL_W-1:0] e_oc;
    logic [DATA_W-1:0] e_od;
    logic [1:0]        e_occ;
  } vec_t;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  task automatic check(input string name, input int idx,
                       input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic iv,
                              input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                              input logic ordy, input logic e_ir, input logic e_ov,
                              input logic [CTRL_W-1:0] e_oc, input logic [DATA_W-1:0] e_od,
                              input logic [1:0] e_occ);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.ctrl = c; v.data = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_oc = e_oc; v.e_od = e_od; v.e_occ = e_occ;
    return v;
  endfunction

  entry_t sb[$];
  entry_t e;
  logic   do_push;
  logic   do_pop;

  initial begin
    // rst  fl  iv  ctrl   data   ordy | ir  ov  oc     od     occ
    // reset held two cycles with a pending input
    vecs[0]  = mk(1, 0, 1, 2'd3, 69'hA5, 0,  1, 0, 2'd0, 69'h0,  2'd0);
    vecs[1]  = mk(1, 0, 1, 2'd3, 69'hA5, 0,  1, 0, 2'd0, 69'h0,  2'd0);
    // streaming with out_ready=1
    vecs[2]  = mk(0, 0, 1, 2'd1, 69'h1,  1,  1, 1, 2'd1, 69'h1,  2'd1);
    vecs[3]  = mk(0, 0, 1, 2'd2, 69'h2,  1,  1, 1, 2'd2, 69'h2,  2'd1);
    vecs[4]  = mk(0, 0, 1, 2'd1, 69'h3,  1,  1, 1, 2'd1, 69'h3,  2'd1);
    vecs[5]  = mk(0, 0, 0, 2'd0, 69'h0,  1,  1, 0, 2'd0, 69'h3,  2'd0);
    // back-pressure: 7, 8 fill, 9 ignored, then drain
    vecs[6]  = mk(0, 0, 1, 2'd1, 69'h7,  0,  1, 1, 2'd1, 69'h7,  2'd1);
    vecs[7]  = mk(0, 0, 1, 2'd2, 69'h8,  0,  0, 1, 2'd1, 69'h7,  2'd2);
    vecs[8]  = mk(0, 0, 1, 2'd3, 69'h9,  0,  0, 1, 2'd1, 69'h7,  2'd2);
    vecs[9]  = mk(0, 0, 1, 2'd3, 69'h9,  1,  1, 1, 2'd2, 69'h8,  2'd1);
    vecs[10] = mk(0, 0, 0, 2'd0, 69'h0,  1,  1, 0, 2'd0, 69'h8,  2'd0);
    // flush in FULL with a simultaneous push of 0x55
    vecs[11] = mk(0, 0, 1, 2'd1, 69'hA,  0,  1, 1, 2'd1, 69'hA,  2'd1);
    vecs[12] = mk(0, 0, 1, 2'd2, 69'hB,  0,  0, 1, 2'd1, 69'hA,  2'd2);
    vecs[13] = mk(0, 1, 1, 2'd3, 69'h55, 1,  1, 0, 2'd0, 69'h0,  2'd0);
    vecs[14] = mk(0, 0, 0, 2'd0, 69'h0,  1,  1, 0, 2'd0, 69'h0,  2'd0);
    // bubble: ctrl=3 visible for exactly one cycle
    vecs[15] = mk(0, 0, 1, 2'd3, 69'h33, 0,  1, 1, 2'd3, 69'h33, 2'd1);
    vecs[16] = mk(0, 0, 0, 2'd3, 69'h0,  1,  1, 0, 2'd0, 69'h33, 2'd0);
    vecs[17] = mk(0, 0, 0, 2'd0, 69'h0,  1,  1, 0, 2'd0, 69'h33, 2'd0);
    // flush in ONE, wide payload restored to reset value
    vecs[18] = mk(0, 0, 1, 2'd1, {1'b1, 68'h0}, 0, 1, 1, 2'd1, {1'b1, 68'h0}, 2'd1);
    vecs[19] = mk(0, 1, 0, 2'd0, 69'h0,  1,  1, 0, 2'd0, 69'h0,  2'd0);

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    #1;
    for (int i = 0; i < NVEC; i++) begin
      rst       = vecs[i].rst;
      flush     = vecs[i].flush;
      in_valid  = vecs[i].iv;
      in_ctrl   = vecs[i].ctrl;
      in_data   = vecs[i].data;
      out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      check("in_ready",  i, DATA_W'(in_ready),  DATA_W'(vecs[i].e_ir));
      check("out_valid", i, DATA_W'(out_valid), DATA_W'(vecs[i].e_ov));
      check("out_ctrl",  i, DATA_W'(out_ctrl),  DATA_W'(vecs[i].e_oc));
      check("out_data",  i, out_data,           vecs[i].e_od);
      check("occupancy", i, DATA_W'(occupancy), DATA_W'(vecs[i].e_occ));
    end

    // Randomized traffic against a FIFO scoreboard
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_ctrl   = CTRL_W'($urandom);
      in_data   = {32'($urandom), 32'($urandom), 5'($urandom)};
      @(negedge clk);
      check("rnd_out_valid", cyc, DATA_W'(out_valid), DATA_W'(sb.size() > 0));
      check("rnd_in_ready",  cyc, DATA_W'(in_ready),  DATA_W'(sb.size() < 2));
      check("rnd_occupancy", cyc, DATA_W'(occupancy), DATA_W'(sb.size()));
      if (sb.size() > 0) begin
        check("rnd_out_data", cyc, out_data,           sb[0].data);
        check("rnd_out_ctrl", cyc, DATA_W'(out_ctrl),  DATA_W'(sb[0].ctrl));
      end else begin
        check("rnd_bubble_ctrl", cyc, DATA_W'(out_ctrl), '0);
      end
      do_push = in_valid && (sb.size() < 2);
      do_pop  = out_ready && (sb.size() > 0);
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        e.ctrl = in_ctrl;
        e.data = in_data;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
